// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential lab calculator.
package calc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_SHL = 3'b110,
      OP_INV = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bits of b used as the SHL amount.
   function automatic int unsigned shamt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_calculator_if.sv
// Start/done handshake and result bus between the input logic and the calculator.
interface seq_calculator_if
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   op_t              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             err;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry, zero, err
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry, zero, err
   );

endinterface

// File: rtl/calc_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, WIDTH steps per product.
module calc_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 step,
   output logic [2*WIDTH-1:0]   product,
   output logic                 last
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    acc_next;

   // product is the accumulator after the current step, so the caller can
   // capture the final value on the same edge as the last step.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   assign product = acc_next;
   assign last    = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Clocked calculator: single-cycle ALU ops, iterative multiply, start/done handshake.
module seq_calculator
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   seq_calculator_if.slave bus
);

   localparam int unsigned SW = shamt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   op_t              op_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic             err_q;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_err;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH:0]     shl_ext;
   logic [SW-1:0]      shamt;

   logic               mul_load;
   logic               mul_step;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_last;

   // Single-cycle ALU on the captured operands.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_err   = 1'b0;
      sum       = {1'b0, a_q} + {1'b0, b_q};
      diff      = {1'b0, a_q} - {1'b0, b_q};
      shamt     = b_q[SW-1:0];
      shl_ext   = {1'b0, a_q} << shamt;
      case (op_q)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
         end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_SHL: begin
            alu_res   = shl_ext[WIDTH-1:0];
            alu_carry = (shamt != '0) ? shl_ext[WIDTH] : 1'b0;
         end
         default: alu_err = 1'b1;
      endcase
   end

   assign mul_load = (state == IDLE) && bus.start && (bus.op == OP_MUL);
   assign mul_step = (state == MUL);

   calc_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (mul_load),
      .a       (bus.a),
      .b       (bus.b),
      .step    (mul_step),
      .product (mul_prod),
      .last    (mul_last)
   );

   // Control FSM; flags only change on the transition into DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  op_q   <= bus.op;
                  busy_q <= 1'b1;
                  state  <= (bus.op == OP_MUL) ? MUL : EXEC;
               end
            end
            EXEC: begin
               result_q <= alu_res;
               carry_q  <= alu_carry;
               zero_q   <= (alu_res == '0);
               err_q    <= alu_err;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state    <= DONE;
            end
            MUL: begin
               if (mul_last) begin
                  result_q <= mul_prod[WIDTH-1:0];
                  carry_q  <= |mul_prod[2*WIDTH-1:WIDTH];
                  zero_q   <= (mul_prod[WIDTH-1:0] == '0);
                  err_q    <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.zero   = zero_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed-vector bench for seq_calculator at WIDTH=8.
module tb_seq_calculator;
   import calc_pkg::*;

   localparam int unsigned W = 8;
   localparam int NVEC = 13;

   typedef struct {
      op_t        op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       e;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   seq_calculator_if #(.WIDTH(W)) bus ();

   seq_calculator #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Issue one op, scramble inputs after capture, and wait (bounded) for done.
   task automatic run_op(input op_t o, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output logic busy_ok);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = op_t'($urandom_range(0, 7));
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.done) begin
            if (bus.busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   vec_t vecs[NVEC];

   initial begin
      int   lat;
      logic bok;
      int   dones;
      int   done_at;

      vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1'b0, 2};
      vecs[1]  = '{OP_SUB, 8'd5,   8'd5,   8'd0,   1'b0, 1'b1, 1'b0, 2};
      vecs[2]  = '{OP_SUB, 8'd3,   8'd7,   8'd252, 1'b1, 1'b0, 1'b0, 2};
      vecs[3]  = '{OP_MUL, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 1'b0, 9};
      vecs[4]  = '{OP_MUL, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1, 1'b0, 9};
      vecs[5]  = '{OP_INV, 8'd9,   8'd4,   8'd0,   1'b0, 1'b1, 1'b1, 2};
      vecs[6]  = '{OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 2};
      vecs[7]  = '{OP_SHL, 8'h81,  8'h01,  8'h02,  1'b1, 1'b0, 1'b0, 2};
      vecs[8]  = '{OP_OR,  8'hA0,  8'h05,  8'hA5,  1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{OP_XOR, 8'hFF,  8'h0F,  8'hF0,  1'b0, 1'b0, 1'b0, 2};
      vecs[10] = '{OP_SHL, 8'h01,  8'h08,  8'h01,  1'b0, 1'b0, 1'b0, 2};
      vecs[11] = '{OP_MUL, 8'd255, 8'd255, 8'h01,  1'b1, 1'b0, 1'b0, 9};
      vecs[12] = '{OP_SHL, 8'h40,  8'h03,  8'h00,  1'b0, 1'b1, 1'b0, 2};

      // Reset with random inputs.
      reset     = 1'b1;
      bus.start = 1'($urandom);
      bus.op    = op_t'($urandom_range(0, 7));
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_zero",   32'(bus.zero),   32'd1);
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_done",   32'(bus.done),   32'd0);
      chk("rst_err",    32'(bus.err),    32'd0);
      chk("rst_carry",  32'(bus.carry),  32'd0);
      bus.start = 1'b0;
      reset     = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
         chk($sformatf("v%0d_lat", i),    32'(lat),        32'(vecs[i].lat));
         chk($sformatf("v%0d_busy", i),   32'(bok),        32'd1);
         chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
         chk($sformatf("v%0d_carry", i),  32'(bus.carry),  32'(vecs[i].c));
         chk($sformatf("v%0d_zero", i),   32'(bus.zero),   32'(vecs[i].z));
         chk($sformatf("v%0d_err", i),    32'(bus.err),    32'(vecs[i].e));
      end

      // Flags hold through IDLE.
      repeat (3) @(negedge clk);
      chk("hold_result", 32'(bus.result), 32'h00);
      chk("hold_zero",   32'(bus.zero),   32'd1);
      chk("hold_done",   32'(bus.done),   32'd0);

      // start/operand churn during MUL must not restart or corrupt it.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.a     = 8'd15;
      bus.b     = 8'd17;
      @(posedge clk);
      dones   = 0;
      done_at = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (bus.done) begin
            dones++;
            done_at = c;
         end
         if (c == 8) chk("churn_busy8", 32'(bus.busy), 32'd1);
         if (c <= 8) begin
            bus.start = 1'(c % 2);
            bus.op    = op_t'($urandom_range(0, 7));
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      chk("churn_dones",  32'(dones),      32'd1);
      chk("churn_doneat", 32'(done_at),    32'd9);
      chk("churn_result", 32'(bus.result), 32'd255);
      chk("churn_carry",  32'(bus.carry),  32'd0);
      chk("churn_busy",   32'(bus.busy),   32'd0);

      // Reset in the 4th MUL cycle aborts without a done pulse.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.a     = 8'd200;
      bus.b     = 8'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_pre", 32'(bus.busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy",   32'(bus.busy),   32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_zero",   32'(bus.zero),   32'd1);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_nodone", 32'(dones), 32'd0);

      run_op(OP_ADD, 8'd1, 8'd1, lat, bok);
      chk("post_lat",    32'(lat),        32'd2);
      chk("post_result", 32'(bus.result), 32'd2);
      chk("post_carry",  32'(bus.carry),  32'd0);
      chk("post_zero",   32'(bus.zero),   32'd0);
      @(negedge clk);
      chk("post_pulse",  32'(bus.done),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
